harvard_mem_arbiter: RTL and testbench
======================================

# harvard_mem_arbiter

Sequencer that lets `mips_cpu_harvard` run from one shared single-port memory bus. Each CPU cycle is split into an instruction-fetch bus transfer, then an optional data transfer, and ends with a single `clk_enable` pulse. While a transfer is in progress, the CPU is frozen by holding its clock enable low, and its combinational read ports see registered, stable data. The block sits between the CPU's Harvard ports and the memory or peripheral bus.

## Interface
- `TIMEOUT`, 255: maximum wait-state cycles allowed per transfer before it is abandoned.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `cpu_active` in 1: CPU `active` output.
- `cpu_instr_address` in 32: CPU fetch byte address.
- `cpu_instr_readdata` out 32: latched instruction word.
- `cpu_data_address` in 32: CPU data byte address.
- `cpu_data_read` in 1: CPU data read request.
- `cpu_data_write` in 1: CPU data write request.
- `cpu_data_writedata` in 32: CPU store data.
- `cpu_data_readdata` out 32: latched load data.
- `cpu_clk_enable` out 1: drives CPU `clk_enable`.
- `mem_address` out 32: bus byte address, passed through unaligned/unmodified.
- `mem_read` out 1: bus read strobe.
- `mem_write` out 1: bus write strobe.
- `mem_writedata` out 32: bus write data.
- `mem_readdata` in 32: bus read data.
- `mem_waitrequest` in 1: bus stall.
- `bus_error` out 1: sticky flag, set on timeout.

## Operation
- States:
  - FETCH: `mem_read`=1, `mem_address`=`cpu_instr_address`.
  - DATA: drives the data access, if any.
  - EXEC: `cpu_clk_enable`=1.
  - HALT: idle.
- Transfer completion: a transfer completes on an edge where a strobe is high and `mem_waitrequest`=0. `mem_readdata` is sampled at that edge.
- FETCH completion: latch `cpu_instr_readdata`, go to DATA.
- DATA state:
  - CPU decode outputs are valid because `cpu_instr_readdata` is now stable.
  - `cpu_data_read` only: `mem_read`=1, `mem_address`=`cpu_data_address`. On completion, latch `cpu_data_readdata`, go to EXEC.
  - `cpu_data_write`: `mem_write`=1, with address and `mem_writedata`=`cpu_data_writedata`. On completion, go to EXEC.
  - Read and write both high: the write is performed; `cpu_data_readdata` is unchanged.
  - Neither: no strobe; go to EXEC after 1 cycle.
- EXEC: exactly one cycle, no bus strobes. Next state is FETCH if `cpu_active`=1 during EXEC, else HALT.
- HALT: all strobes 0, `cpu_clk_enable`=0. Left only by reset.
- Wait counter: 8-bit minimum, cleared on entry to FETCH or DATA, increments per stalled cycle.
  - When it reaches `TIMEOUT`, the transfer is abandoned and `bus_error` is set.
  - Read timeout: the target register loads 32'hFFFFFFFF.
  - The state machine then advances as if the transfer had completed.
- Bus outputs are 0 whenever no strobe is asserted.
- Reset values: FETCH state after release; `cpu_clk_enable`=0, both readdata registers=0, `mem_read`/`mem_write`=0, `mem_address`/`mem_writedata`=0, `bus_error`=0, wait counter 0.
- Reset asserted mid-transfer drops strobes asynchronously, with no completion. Bus slaves tolerate an aborted strobe.

## Timing
- Zero-wait bus: FETCH 1 + DATA 1 + EXEC 1 = 3 cycles per CPU instruction. Each wait state adds 1 cycle.
- `cpu_clk_enable` is high for exactly one cycle per instruction and is never high in FETCH or DATA.
- CPU-facing readdata changes only at transfer-completion edges, never in EXEC.
- First fetch strobe is on the first cycle after reset release.
- Strobes hold address and data stable until completion.
- Timeout: the abandon happens on the edge where the counter equals `TIMEOUT`. `bus_error` is visible the next cycle.

## Test plan
- **Reset:** assert `reset`=0 mid-DATA with `mem_read`=1 and no clock edge.
  - All outputs go 0 immediately.
  - After release, `mem_read`=1 with `mem_address`=`cpu_instr_address` on the first cycle.
- **Load then jump, zero-wait:**
  - Fetch `lw $12,0($0)` (32'h8C0C0000); the data read returns 32'hB000FFFF.
  - Then fetch `jr $12` (32'h01800008), which has no data access.
  - Required: each instruction takes 3 cycles; after the jr EXEC, the next FETCH `mem_address`=32'hB000FFFF.
- **Store:** `sw` to 32'h00000400 with data 32'h12345678.
  - Exactly one `mem_write` completion, with that address and data.
  - `cpu_clk_enable` pulses once, only afterwards.
- **Wait states:** hold `mem_waitrequest`=1 for 4 cycles on fetch and 2 on data read.
  - Instruction takes 9 cycles.
  - Readdata outputs change only at the completion edges.
  - `cpu_clk_enable` stays 0 throughout the stalls.
- **Timeout:** with `TIMEOUT`=4 and `mem_waitrequest` stuck at 1 during FETCH.
  - Abandon after 4 stalled cycles; `cpu_instr_readdata`=32'hFFFFFFFF.
  - `bus_error`=1 and stays high until reset.
- **Halt:** `cpu_active`=0 during EXEC.
  - State goes to HALT: no further strobes, `cpu_clk_enable`=0 for 20 cycles.

Source files
------------

// File: rtl/harvard_mem_arbiter.sv
// Time-multiplexes the Harvard CPU's fetch and data ports onto one single-port bus,
// and freezes the CPU through clk_enable while bus transfers are in flight.
module harvard_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {
    FETCH,
    DATA,
    EXEC,
    HALT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          req_rd;
  logic          req_wr;
  logic          strobe;
  logic          done;
  logic          abandon;
  logic          advance;

  // Strobes are qualified with reset so an asserted reset drops them without waiting for a clock edge.
  always_comb begin
    req_rd  = (state == FETCH) ||
              ((state == DATA) && cpu_data_read && !cpu_data_write);
    req_wr  = (state == DATA) && cpu_data_write;
    strobe  = reset && (req_rd || req_wr);
    done    = strobe && !mem_waitrequest;
    abandon = strobe && mem_waitrequest && (wait_cnt == CW'(TIMEOUT));
    advance = done || abandon;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (advance) state_nxt = DATA;
      DATA:  if (!(req_rd || req_wr) || advance) state_nxt = EXEC;
      EXEC:  state_nxt = cpu_active ? FETCH : HALT;
      HALT:  state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    mem_read       = reset && req_rd;
    mem_write      = reset && req_wr;
    mem_address    = '0;
    mem_writedata  = '0;
    cpu_clk_enable = (state == EXEC);
    if (strobe) begin
      mem_address = (state == FETCH) ? cpu_instr_address : cpu_data_address;
    end
    if (reset && req_wr) begin
      mem_writedata = cpu_data_writedata;
    end
  end

  // Counter idles at zero whenever no strobe is up, so it is already clear on entry to FETCH/DATA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt           <= '0;
      cpu_instr_readdata <= '0;
      cpu_data_readdata  <= '0;
      bus_error          <= 1'b0;
    end else begin
      if (!strobe || advance) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if ((state == FETCH) && advance) begin
        cpu_instr_readdata <= done ? mem_readdata : '1;
      end
      if ((state == DATA) && req_rd && advance) begin
        cpu_data_readdata <= done ? mem_readdata : '1;
      end
      if (abandon) begin
        bus_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_harvard_mem_arbiter.sv
// Bench for harvard_mem_arbiter: acts as CPU and bus slave, compares every cycle
// against a per-instruction phase model (fetch / data / exec lengths from wait counts).
module tb_harvard_mem_arbiter;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_instr;
  logic [31:0] exp_data;
  logic        exp_berr;

  // bus vector: {read, write, address[64:33], writedata[32:1], clk_enable}
  logic [66:0] obs_bus[$];
  logic [66:0] exp_bus_q[$];
  logic [64:0] obs_rd[$];
  logic [64:0] exp_rd_q[$];

  always #5 clk = ~clk;

  harvard_mem_arbiter #(.TIMEOUT(T)) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_active         (cpu_active),
    .cpu_instr_address  (cpu_instr_address),
    .cpu_instr_readdata (cpu_instr_readdata),
    .cpu_data_address   (cpu_data_address),
    .cpu_data_read      (cpu_data_read),
    .cpu_data_write     (cpu_data_write),
    .cpu_data_writedata (cpu_data_writedata),
    .cpu_data_readdata  (cpu_data_readdata),
    .cpu_clk_enable     (cpu_clk_enable),
    .mem_address        (mem_address),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_writedata      (mem_writedata),
    .mem_readdata       (mem_readdata),
    .mem_waitrequest    (mem_waitrequest),
    .bus_error          (bus_error)
  );

  task automatic idle_inputs();
    cpu_active         = 1'b1;
    cpu_instr_address  = '0;
    cpu_data_address   = '0;
    cpu_data_read      = 1'b0;
    cpu_data_write     = 1'b0;
    cpu_data_writedata = '0;
    mem_readdata       = '0;
    mem_waitrequest    = 1'b0;
  endtask

  // Leaves the bench just after a rising edge with reset released: next negedge is the first FETCH cycle.
  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    reset     = 1'b1;
    exp_instr = '0;
    exp_data  = '0;
    exp_berr  = 1'b0;
  endtask

  // One CPU instruction. kind: 0 none, 1 load, 2 store, 3 read+write. fw/dw: stall cycles offered by the slave.
  task automatic run_instr(input logic [31:0] iaddr, input logic [31:0] iword, input int unsigned fw,
                           input int unsigned kind, input logic [31:0] daddr, input logic [31:0] wdata,
                           input logic [31:0] drd, input int unsigned dw, input logic active);
    int unsigned f_len;
    int unsigned d_len;
    int unsigned n;
    logic [66:0] eb;
    obs_bus.delete();
    exp_bus_q.delete();
    obs_rd.delete();
    exp_rd_q.delete();
    f_len = (fw <= T) ? fw + 1 : T + 1;
    d_len = (kind == 0) ? 1 : ((dw <= T) ? dw + 1 : T + 1);
    n     = f_len + d_len + 1;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_instr_address  = iaddr;
      cpu_data_address   = daddr;
      cpu_data_read      = (kind == 1) || (kind == 3);
      cpu_data_write     = (kind >= 2);
      cpu_data_writedata = wdata;
      cpu_active         = active;
      if (i < f_len) begin
        mem_waitrequest = (i < fw);
        mem_readdata    = mem_waitrequest ? $urandom() : iword;
        eb = {1'b1, 1'b0, iaddr, 32'h0, 1'b0};
      end else if (i < f_len + d_len) begin
        mem_waitrequest = (kind != 0) && ((i - f_len) < dw);
        mem_readdata    = mem_waitrequest ? $urandom() : drd;
        case (kind)
          1:       eb = {1'b1, 1'b0, daddr, 32'h0, 1'b0};
          2, 3:    eb = {1'b0, 1'b1, daddr, wdata, 1'b0};
          default: eb = {2'b00, 64'h0, 1'b0};
        endcase
      end else begin
        mem_waitrequest = 1'($urandom_range(0, 1));
        mem_readdata    = $urandom();
        eb = {2'b00, 64'h0, 1'b1};
      end
      #1;
      obs_bus.push_back({mem_read, mem_write, mem_address, mem_writedata, cpu_clk_enable});
      obs_rd.push_back({cpu_instr_readdata, cpu_data_readdata, bus_error});
      exp_bus_q.push_back(eb);
      exp_rd_q.push_back({exp_instr, exp_data, exp_berr});
      if (i == f_len - 1) begin
        exp_instr = (fw <= T) ? iword : 32'hFFFF_FFFF;
        if (fw > T) exp_berr = 1'b1;
      end
      if ((kind != 0) && (i == f_len + d_len - 1)) begin
        if (kind == 1) exp_data = (dw <= T) ? drd : 32'hFFFF_FFFF;
        if (dw > T) exp_berr = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({mem_read, mem_write, mem_address, mem_writedata, cpu_clk_enable,
         cpu_instr_readdata, cpu_data_readdata, bus_error} !== 132'h0) begin
      errors++;
      $display("FAIL reset_state: got rd=%b wr=%b addr=%h wd=%h ce=%b ir=%h dr=%h be=%b, required all zero",
               mem_read, mem_write, mem_address, mem_writedata, cpu_clk_enable,
               cpu_instr_readdata, cpu_data_readdata, bus_error);
    end
    reset = 1'b1;
    @(negedge clk);
    cpu_instr_address = 32'h0000_1000;
    mem_readdata      = 32'h1234_0000;
    mem_waitrequest   = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, 32'h0000_1000}) begin
      errors++;
      $display("FAIL first_fetch: got rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=00001000",
               mem_read, mem_write, mem_address);
    end
    @(negedge clk);
    cpu_data_read    = 1'b1;
    cpu_data_address = 32'h0000_2000;
    mem_waitrequest  = 1'b1;
    #1;
    checks++;
    if ({mem_read, mem_address, cpu_instr_readdata} !== {1'b1, 32'h0000_2000, 32'h1234_0000}) begin
      errors++;
      $display("FAIL mid_data: got rd=%b addr=%h ir=%h, required rd=1 addr=00002000 ir=12340000",
               mem_read, mem_address, cpu_instr_readdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, mem_address, mem_writedata, cpu_clk_enable,
         cpu_instr_readdata, cpu_data_readdata, bus_error} !== 132'h0) begin
      errors++;
      $display("FAIL async_reset: got rd=%b wr=%b addr=%h ce=%b ir=%h dr=%h be=%b, required all zero",
               mem_read, mem_write, mem_address, cpu_clk_enable,
               cpu_instr_readdata, cpu_data_readdata, bus_error);
    end
    @(posedge clk);
    #2;
    reset         = 1'b1;
    cpu_data_read = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, 32'h0000_1000}) begin
      errors++;
      $display("FAIL restart_fetch: got rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=00001000",
               mem_read, mem_write, mem_address);
    end
  endtask

  task automatic test_load_jump();
    logic [31:0] target;
    do_reset();
    run_instr(32'h0, 32'h8C0C_0000, 0, 1, 32'h0, 32'h0, 32'hB000_FFFF, 0, 1'b1);
    for (int k = 0; k < obs_bus.size(); k++) begin
      checks++;
      if (obs_bus[k] !== exp_bus_q[k]) begin
        errors++;
        $display("FAIL lw_bus c%0d: got %h required %h", k, obs_bus[k], exp_bus_q[k]);
      end
      checks++;
      if (obs_rd[k] !== exp_rd_q[k]) begin
        errors++;
        $display("FAIL lw_rdata c%0d: got %h required %h", k, obs_rd[k], exp_rd_q[k]);
      end
    end
    run_instr(32'h4, 32'h0180_0008, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1'b1);
    for (int k = 0; k < obs_bus.size(); k++) begin
      checks++;
      if (obs_bus[k] !== exp_bus_q[k]) begin
        errors++;
        $display("FAIL jr_bus c%0d: got %h required %h", k, obs_bus[k], exp_bus_q[k]);
      end
      checks++;
      if (obs_rd[k] !== exp_rd_q[k]) begin
        errors++;
        $display("FAIL jr_rdata c%0d: got %h required %h", k, obs_rd[k], exp_rd_q[k]);
      end
    end
    target = exp_data;
    run_instr(target, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1'b1);
    checks++;
    if (obs_bus[0][64:33] !== 32'hB000_FFFF) begin
      errors++;
      $display("FAIL jr_target: got addr %h required B000FFFF", obs_bus[0][64:33]);
    end
  endtask

  task automatic test_store();
    int nw;
    int first_ce;
    do_reset();
    run_instr(32'h8, 32'hAC0D_0400, 0, 2, 32'h0000_0400, 32'h1234_5678, 32'h0, 0, 1'b1);
    nw = 0;
    first_ce = -1;
    for (int k = 0; k < obs_bus.size(); k++) begin
      checks++;
      if (obs_bus[k] !== exp_bus_q[k]) begin
        errors++;
        $display("FAIL sw_bus c%0d: got %h required %h", k, obs_bus[k], exp_bus_q[k]);
      end
      if (obs_bus[k][65]) nw++;
      if (obs_bus[k][0] && first_ce < 0) first_ce = k;
    end
    checks++;
    if (nw != 1) begin
      errors++;
      $display("FAIL sw_count: got %0d write cycles required 1", nw);
    end
    checks++;
    if (first_ce != 2) begin
      errors++;
      $display("FAIL sw_ce_order: got clk_enable first at cycle %0d required 2", first_ce);
    end
  endtask

  task automatic test_wait_states();
    int first_ce;
    run_instr(32'hC, 32'h8C0E_0010, 4, 1, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 2, 1'b1);
    first_ce = -1;
    for (int k = 0; k < obs_bus.size(); k++) begin
      checks++;
      if (obs_bus[k] !== exp_bus_q[k]) begin
        errors++;
        $display("FAIL wait_bus c%0d: got %h required %h", k, obs_bus[k], exp_bus_q[k]);
      end
      checks++;
      if (obs_rd[k] !== exp_rd_q[k]) begin
        errors++;
        $display("FAIL wait_rdata c%0d: got %h required %h", k, obs_rd[k], exp_rd_q[k]);
      end
      if (obs_bus[k][0] && first_ce < 0) first_ce = k;
    end
    checks++;
    if (first_ce != 8) begin
      errors++;
      $display("FAIL wait_len: got clk_enable at cycle %0d required 8", first_ce);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h100;
    for (int n = 0; n < 40; n++) begin
      run_instr(pc, $urandom(), $urandom_range(0, 6), $urandom_range(0, 3), $urandom(), $urandom(),
                $urandom(), $urandom_range(0, 6), 1'b1);
      for (int k = 0; k < obs_bus.size(); k++) begin
        checks++;
        if (obs_bus[k] !== exp_bus_q[k]) begin
          errors++;
          $display("FAIL rand_bus i%0d c%0d: got %h required %h", n, k, obs_bus[k], exp_bus_q[k]);
        end
        checks++;
        if (obs_rd[k] !== exp_rd_q[k]) begin
          errors++;
          $display("FAIL rand_rdata i%0d c%0d: got %h required %h", n, k, obs_rd[k], exp_rd_q[k]);
        end
      end
      pc = pc + 32'd4;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_instr(32'h200, 32'h1111_2222, 10, 0, 32'h0, 32'h0, 32'h0, 0, 1'b1);
    for (int k = 0; k < obs_bus.size(); k++) begin
      checks++;
      if (obs_bus[k] !== exp_bus_q[k]) begin
        errors++;
        $display("FAIL tmo_bus c%0d: got %h required %h", k, obs_bus[k], exp_bus_q[k]);
      end
      checks++;
      if (obs_rd[k] !== exp_rd_q[k]) begin
        errors++;
        $display("FAIL tmo_rdata c%0d: got %h required %h", k, obs_rd[k], exp_rd_q[k]);
      end
    end
    checks++;
    if (obs_rd[T + 1][64:33] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL tmo_instr: got %h required FFFFFFFF", obs_rd[T + 1][64:33]);
    end
    run_instr(32'h204, 32'h0000_0000, 1, 1, 32'h40, 32'h0, 32'h5555_AAAA, 0, 1'b1);
    checks++;
    if (bus_error !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: got bus_error %b required 1", bus_error);
    end
  endtask

  task automatic test_halt();
    run_instr(32'h300, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    for (int k = 0; k < obs_bus.size(); k++) begin
      checks++;
      if (obs_bus[k] !== exp_bus_q[k]) begin
        errors++;
        $display("FAIL halt_entry c%0d: got %h required %h", k, obs_bus[k], exp_bus_q[k]);
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cpu_active        = 1'($urandom_range(0, 1));
      cpu_data_read     = 1'($urandom_range(0, 1));
      cpu_data_write    = 1'($urandom_range(0, 1));
      cpu_instr_address = $urandom();
      cpu_data_address  = $urandom();
      mem_waitrequest   = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({mem_read, mem_write, mem_address, mem_writedata, cpu_clk_enable} !== 67'h0) begin
        errors++;
        $display("FAIL halt_idle c%0d: got rd=%b wr=%b addr=%h ce=%b required all zero",
                 k, mem_read, mem_write, mem_address, cpu_clk_enable);
      end
    end
  endtask

  initial begin
    exp_instr = '0;
    exp_data  = '0;
    exp_berr  = 1'b0;
    test_reset();
    test_load_jump();
    test_store();
    test_wait_states();
    test_random();
    test_timeout();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
